// File: rtl/calc_entry_controller.sv
`default_nettype none
// ============================================================================
// Module   : calc_entry_controller
// Purpose  : Keypad-to-ALU sequencer: builds two signed operands and an
//            operator from keystrokes, runs one ALU transaction, shows result.
// Revision : 1.0 - initial release
// ============================================================================
module calc_entry_controller #(
    parameter int MAXMAG = 32767
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        KeyRdy,
    input  logic [3:0]  RowColVector,
    output logic        KeyRd,
    output logic [15:0] OpA,
    output logic [15:0] OpB,
    output logic [1:0]  Op,
    output logic        Start,
    input  logic        Done,
    input  logic [15:0] Result,
    input  logic        Ovf,
    output logic [15:0] Display,
    output logic        OvfFlag,
    output logic        KeyErr
);

    localparam logic [1:0] c_ST_ENTRY_A = 2'd0;
    localparam logic [1:0] c_ST_ENTRY_B = 2'd1;
    localparam logic [1:0] c_ST_EXEC    = 2'd2;
    localparam logic [1:0] c_ST_RESULT  = 2'd3;

    localparam logic [3:0] c_KEY_ADD = 4'd10;
    localparam logic [3:0] c_KEY_SUB = 4'd11;
    localparam logic [3:0] c_KEY_NEG = 4'd12;
    localparam logic [3:0] c_KEY_CLR = 4'd13;
    localparam logic [3:0] c_KEY_EQ  = 4'd14;
    localparam logic [3:0] c_KEY_MUL = 4'd15;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_armed;
    logic [14:0] r_mag_a;
    logic [14:0] r_mag_b;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [15:0] r_res;

    logic [3:0]  w_key;
    logic        w_accept;
    logic        w_is_digit;
    logic        w_is_op;
    logic [1:0]  w_op_code;
    logic [14:0] w_mag_sel;
    logic [18:0] w_next_mag;
    logic        w_digit_ok;
    logic [15:0] w_res_abs;
    logic        w_done;

    assign w_key      = {RowColVector[1:0], RowColVector[3:2]};
    assign w_accept   = KeyRdy & r_armed & (r_state != c_ST_EXEC);
    assign w_is_digit = (w_key <= 4'd9);
    assign w_is_op    = (w_key == c_KEY_ADD) | (w_key == c_KEY_SUB) | (w_key == c_KEY_MUL);
    assign w_op_code  = (w_key == c_KEY_ADD) ? 2'b00 :
                        (w_key == c_KEY_SUB) ? 2'b01 : 2'b10;

    assign w_mag_sel  = (r_state == c_ST_ENTRY_B) ? r_mag_b : r_mag_a;
    assign w_next_mag = {w_mag_sel, 3'b000} + {3'b000, w_mag_sel, 1'b0} + {15'd0, w_key};
    assign w_digit_ok = (w_next_mag <= 19'(MAXMAG));
    assign w_res_abs  = r_res[15] ? (16'd0 - r_res) : r_res;

    // Done in the Start cycle is the ALU echoing a stale request; ignore it.
    assign w_done     = (r_state == c_ST_EXEC) & Done & ~Start;

    assign OpA = r_sign_a ? (16'd0 - {1'b0, r_mag_a}) : {1'b0, r_mag_a};
    assign OpB = r_sign_b ? (16'd0 - {1'b0, r_mag_b}) : {1'b0, r_mag_b};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_ST_ENTRY_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept && (w_key == c_KEY_CLR)) begin
            w_state_next = c_ST_ENTRY_A;
        end else begin
            case (r_state)
                c_ST_ENTRY_A: if (w_accept && w_is_op) w_state_next = c_ST_ENTRY_B;
                c_ST_ENTRY_B: if (w_accept && (w_key == c_KEY_EQ)) w_state_next = c_ST_EXEC;
                c_ST_EXEC:    if (w_done) w_state_next = c_ST_RESULT;
                default: begin
                    if (w_accept && w_is_digit)   w_state_next = c_ST_ENTRY_A;
                    else if (w_accept && w_is_op) w_state_next = c_ST_ENTRY_B;
                end
            endcase
        end
    end

    always_comb begin
        case (r_state)
            c_ST_ENTRY_A: Display = OpA;
            c_ST_RESULT:  Display = r_res;
            default:      Display = OpB;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_armed  <= 1'b1;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_res    <= '0;
            Op       <= 2'b00;
            KeyRd    <= 1'b0;
            KeyErr   <= 1'b0;
            Start    <= 1'b0;
            OvfFlag  <= 1'b0;
        end else begin
            KeyRd  <= w_accept;
            KeyErr <= 1'b0;
            Start  <= w_accept & (r_state == c_ST_ENTRY_B) & (w_key == c_KEY_EQ);

            if (w_accept)      r_armed <= 1'b0;
            else if (!KeyRdy)  r_armed <= 1'b1;

            if (w_done) begin
                r_res   <= Result;
                OvfFlag <= Ovf;
            end

            if (w_accept) begin
                if (w_key == c_KEY_CLR) begin
                    r_mag_a  <= '0;
                    r_mag_b  <= '0;
                    r_sign_a <= 1'b0;
                    r_sign_b <= 1'b0;
                    Op       <= 2'b00;
                    OvfFlag  <= 1'b0;
                end else if (r_state == c_ST_ENTRY_A) begin
                    if (w_is_digit) begin
                        if (w_digit_ok) r_mag_a <= w_next_mag[14:0];
                        else            KeyErr  <= 1'b1;
                    end else if (w_key == c_KEY_NEG) begin
                        r_sign_a <= ~r_sign_a;
                    end else if (w_is_op) begin
                        Op       <= w_op_code;
                        r_mag_b  <= '0;
                        r_sign_b <= 1'b0;
                    end
                end else if (r_state == c_ST_ENTRY_B) begin
                    if (w_is_digit) begin
                        if (w_digit_ok) r_mag_b <= w_next_mag[14:0];
                        else            KeyErr  <= 1'b1;
                    end else if (w_key == c_KEY_NEG) begin
                        r_sign_b <= ~r_sign_b;
                    end else if (w_is_op) begin
                        Op <= w_op_code;
                    end
                end else begin
                    if (w_is_digit) begin
                        r_mag_a  <= {11'd0, w_key};
                        r_sign_a <= 1'b0;
                    end else if (w_key == c_KEY_NEG) begin
                        r_res <= 16'd0 - r_res;
                    end else if (w_is_op) begin
                        // -32768 has no 15-bit magnitude; clamp and flag it.
                        if (r_res == 16'h8000) begin
                            r_mag_a <= 15'h7FFF;
                            KeyErr  <= 1'b1;
                        end else begin
                            r_mag_a <= w_res_abs[14:0];
                        end
                        r_sign_a <= r_res[15];
                        Op       <= w_op_code;
                        r_mag_b  <= '0;
                        r_sign_b <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_entry_controller
// Purpose  : Scoreboard bench for calc_entry_controller key entry and ALU flow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_entry_controller;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        KeyRdy = 1'b0;
    logic [3:0]  RowColVector = 4'd0;
    logic        KeyRd;
    logic [15:0] OpA;
    logic [15:0] OpB;
    logic [1:0]  Op;
    logic        Start;
    logic        Done = 1'b0;
    logic [15:0] Result = 16'd0;
    logic        Ovf = 1'b0;
    logic [15:0] Display;
    logic        OvfFlag;
    logic        KeyErr;

    int vectors = 0;
    int miscompares = 0;
    int keyrd_cnt = 0;
    int start_cnt = 0;

    logic [16:0] key_q[$];   // {expected Display, expected KeyErr}
    logic [33:0] alu_q[$];   // {expected OpA, OpB, Op}

    calc_entry_controller #(.MAXMAG(32767)) dut (
        .Clock(Clock), .Reset(Reset), .KeyRdy(KeyRdy), .RowColVector(RowColVector),
        .KeyRd(KeyRd), .OpA(OpA), .OpB(OpB), .Op(Op), .Start(Start), .Done(Done),
        .Result(Result), .Ovf(Ovf), .Display(Display), .OvfFlag(OvfFlag), .KeyErr(KeyErr)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (KeyRd) keyrd_cnt <= keyrd_cnt + 1;
        if (Start) start_cnt <= start_cnt + 1;
    end

    function automatic logic [3:0] enc(input logic [3:0] k);
        return {k[1:0], k[3:2]};
    endfunction

    task automatic press(input logic [3:0] k, input logic [15:0] exp_disp, input logic exp_err);
        logic [16:0] e;
        logic [33:0] a;
        bit seen;
        key_q.push_back({exp_disp, exp_err});
        @(negedge Clock);
        KeyRdy = 1'b1;
        RowColVector = enc(k);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clock);
            if (KeyRd) seen = 1'b1;
        end
        e = key_q.pop_front();
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL key%0d_timeout: no KeyRd, required a pulse", k);
        end else begin
            if (Display !== e[16:1] || KeyErr !== e[0]) begin
                miscompares++;
                $display("FAIL key%0d: Display=%h KeyErr=%b, required Display=%h KeyErr=%b",
                         k, Display, KeyErr, e[16:1], e[0]);
            end
            if (Start) begin
                vectors++;
                if (alu_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_start: Start=1, required 0");
                end else begin
                    a = alu_q.pop_front();
                    if ({OpA, OpB, Op} !== a) begin
                        miscompares++;
                        $display("FAIL alu_req: OpA=%h OpB=%h Op=%b, required OpA=%h OpB=%h Op=%b",
                                 OpA, OpB, Op, a[33:18], a[17:2], a[1:0]);
                    end
                end
            end
        end
        KeyRdy = 1'b0;
        @(negedge Clock);
    endtask

    task automatic respond(input logic [15:0] res, input logic ovf);
        @(negedge Clock);
        Done = 1'b1; Result = res; Ovf = ovf;
        @(negedge Clock);
        Done = 1'b0;
        vectors++;
        if (Display !== res || OvfFlag !== ovf || alu_q.size() != 0) begin
            miscompares++;
            $display("FAIL alu_resp: Display=%h OvfFlag=%b pending=%0d, required Display=%h OvfFlag=%b pending=0",
                     Display, OvfFlag, alu_q.size(), res, ovf);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clock);
        vectors++;
        if ({KeyRd, Start, KeyErr, OvfFlag, Display, OpA, OpB, Op} !== 54'd0) begin
            miscompares++;
            $display("FAIL reset: KeyRd=%b Start=%b KeyErr=%b OvfFlag=%b Display=%h OpA=%h OpB=%h Op=%b, required all 0",
                     KeyRd, Start, KeyErr, OvfFlag, Display, OpA, OpB, Op);
        end
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_digits;
        int c0 = keyrd_cnt;
        press(4'd1, 16'd1, 1'b0);
        press(4'd2, 16'd12, 1'b0);
        press(4'd3, 16'd123, 1'b0);
        vectors++;
        if (OpA !== 16'd123 || keyrd_cnt - c0 != 3) begin
            miscompares++;
            $display("FAIL digits: OpA=%0d pulses=%0d, required OpA=123 pulses=3", OpA, keyrd_cnt - c0);
        end
    endtask

    task automatic test_maxmag;
        press(4'd13, 16'd0, 1'b0);
        press(4'd3, 16'd3, 1'b0);
        press(4'd2, 16'd32, 1'b0);
        press(4'd7, 16'd327, 1'b0);
        press(4'd6, 16'd3276, 1'b0);
        press(4'd7, 16'd32767, 1'b0);
        press(4'd1, 16'd32767, 1'b1);
    endtask

    task automatic test_compute;
        int s0;
        press(4'd13, 16'd0, 1'b0);
        press(4'd5, 16'd5, 1'b0);
        press(4'd12, 16'hFFFB, 1'b0);
        press(4'd10, 16'd0, 1'b0);
        press(4'd9, 16'd9, 1'b0);
        press(4'd12, 16'hFFF7, 1'b0);
        s0 = start_cnt;
        alu_q.push_back({16'hFFFB, 16'hFFF7, 2'b00});
        press(4'd14, 16'hFFF7, 1'b0);
        respond(16'hFFF2, 1'b0);
        vectors++;
        if (start_cnt - s0 != 1) begin
            miscompares++;
            $display("FAIL start_once: pulses=%0d, required 1", start_cnt - s0);
        end
    endtask

    task automatic test_hold_and_exec_pending;
        int c0;
        bit seen;
        press(4'd13, 16'd0, 1'b0);
        c0 = keyrd_cnt;
        @(negedge Clock);
        KeyRdy = 1'b1; RowColVector = enc(4'd4);
        repeat (6) @(negedge Clock);
        KeyRdy = 1'b0;
        @(negedge Clock);
        vectors++;
        if (keyrd_cnt - c0 != 1 || Display !== 16'd4) begin
            miscompares++;
            $display("FAIL hold: pulses=%0d Display=%0d, required pulses=1 Display=4", keyrd_cnt - c0, Display);
        end
        press(4'd10, 16'd0, 1'b0);
        press(4'd2, 16'd2, 1'b0);
        alu_q.push_back({16'd4, 16'd2, 2'b00});
        press(4'd14, 16'd2, 1'b0);
        c0 = keyrd_cnt;
        KeyRdy = 1'b1; RowColVector = enc(4'd7);
        repeat (5) @(negedge Clock);
        vectors++;
        if (keyrd_cnt != c0) begin
            miscompares++;
            $display("FAIL exec_pending: pulses=%0d during EXEC, required 0", keyrd_cnt - c0);
        end
        Done = 1'b1; Result = 16'd6; Ovf = 1'b0;
        @(negedge Clock);
        Done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (KeyRd) seen = 1'b1;
            else @(negedge Clock);
        end
        vectors++;
        if (!seen || Display !== 16'd7) begin
            miscompares++;
            $display("FAIL after_exec_key: KeyRd_seen=%b Display=%0d, required seen=1 Display=7", seen, Display);
        end
        KeyRdy = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_chain_and_clear;
        press(4'd13, 16'd0, 1'b0);
        press(4'd4, 16'd4, 1'b0);
        press(4'd0, 16'd40, 1'b0);
        press(4'd10, 16'd0, 1'b0);
        press(4'd2, 16'd2, 1'b0);
        alu_q.push_back({16'd40, 16'd2, 2'b00});
        press(4'd14, 16'd2, 1'b0);
        respond(16'd42, 1'b0);
        press(4'd11, 16'd0, 1'b0);
        press(4'd2, 16'd2, 1'b0);
        alu_q.push_back({16'd42, 16'd2, 2'b01});
        press(4'd14, 16'd2, 1'b0);
        respond(16'd40, 1'b1);
        press(4'd13, 16'd0, 1'b0);
        vectors++;
        if (OvfFlag !== 1'b0 || Op !== 2'b00) begin
            miscompares++;
            $display("FAIL clear: OvfFlag=%b Op=%b, required 0 and 00", OvfFlag, Op);
        end
        press(4'd5, 16'd5, 1'b0);
    endtask

    task automatic test_saturate_chain;
        press(4'd13, 16'd0, 1'b0);
        press(4'd1, 16'd1, 1'b0);
        press(4'd15, 16'd0, 1'b0);
        press(4'd1, 16'd1, 1'b0);
        alu_q.push_back({16'd1, 16'd1, 2'b10});
        press(4'd14, 16'd1, 1'b0);
        respond(16'h8000, 1'b1);
        press(4'd12, 16'h8000, 1'b0);
        press(4'd10, 16'd0, 1'b1);
        vectors++;
        if (OpA !== 16'h8001 || Op !== 2'b00) begin
            miscompares++;
            $display("FAIL saturate: OpA=%h Op=%b, required OpA=8001 Op=00", OpA, Op);
        end
        press(4'd13, 16'd0, 1'b0);
    endtask

    task automatic test_reset_in_exec;
        int s0;
        press(4'd1, 16'd1, 1'b0);
        press(4'd10, 16'd0, 1'b0);
        press(4'd1, 16'd1, 1'b0);
        alu_q.push_back({16'd1, 16'd1, 2'b00});
        press(4'd14, 16'd1, 1'b0);
        #2 Reset = 1'b0;
        #1;
        vectors++;
        if (Start !== 1'b0 || Display !== 16'd0 || KeyRd !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_exec: Start=%b Display=%h KeyRd=%b, required 0", Start, Display, KeyRd);
        end
        @(negedge Clock);
        Reset = 1'b1;
        s0 = start_cnt;
        @(negedge Clock);
        Done = 1'b1; Result = 16'd99;
        @(negedge Clock);
        Done = 1'b0;
        vectors++;
        if (Display !== 16'd0 || start_cnt != s0) begin
            miscompares++;
            $display("FAIL late_done: Display=%0d starts=%0d, required Display=0 starts=0", Display, start_cnt - s0);
        end
        press(4'd3, 16'd3, 1'b0);
    endtask

    initial begin
        test_reset;
        test_digits;
        test_maxmag;
        test_compute;
        test_hold_and_exec_pending;
        test_chain_and_clear;
        test_saturate_chain;
        test_reset_in_exec;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
